mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Clocked responder for the 64x4 Enable/ReadWrite memory interface. The same pins that a requester drives into the combinational memory drive this block.
- Adds a Ready/Valid handshake, a configurable read latency and a post-reset clear sweep.
- Sits behind any requester FSM or bench that issues writes and read-backs over Enable, ReadWrite, Address and DataIn.

Parameters:
- ADDR_W, 6, address width; depth is 2**ADDR_W words.
- DATA_W, 4, data word width.
- RD_LAT, 2, cycles from the read-accept edge to the Valid edge; legal range 1..4.

Ports:
- Clock  in  1  single clock; rising-edge active.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  request strobe.
- ReadWrite  in  1  0 = write, 1 = read.
- Address  in  ADDR_W  word address.
- DataIn  in  DATA_W  write data.
- Ready  out  1  block can accept a request this cycle.
- DataOut  out  DATA_W  read data; holds the last read response.
- Valid  out  1  one-cycle pulse; DataOut is new this cycle.
- ParityErr  out  1  parity fault flag; see Optional Feature.

Behaviour:
- Interface rules (already decided): one clock, Clock; reset Reset_n is asynchronous and active-low.
- Reset values: state = CLEAR, clear counter = 0, Ready = 0, Valid = 0, DataOut = 0, ParityErr = 0.
- Accept rule: a request is accepted on the rising edge where Enable = 1 and Ready = 1.
  - When Ready = 0, Enable is ignored and nothing is queued.
  - The requester holds Enable, ReadWrite, Address and DataIn stable until the accepting edge.
- CLEAR state:
  - Writes 0 to address cnt, one address per cycle, for cnt = 0 .. 2**ADDR_W-1.
  - The counter is ADDR_W+1 bits, so it ends on the terminal count and does not wrap.
  - After the edge that writes the last address, go to IDLE.
  - With default parameters, Ready first rises after the 64th edge following reset release.
- IDLE state:
  - Ready = 1.
  - Accepted write: the word is stored at the accepting edge and the state stays IDLE, so back-to-back writes run every cycle. No Valid pulse for writes.
  - Accepted read: latch Address, load the latency counter with RD_LAT-1, go to RWAIT.
- RWAIT state:
  - Ready = 0; the counter decrements each edge.
  - At the edge where the counter is 0, DataOut <= mem[latched addr], Valid <= 1, and the state returns to IDLE.
- Read latency: a read accepted at edge k raises Valid after edge k+RD_LAT, for exactly one cycle.
  - Ready is high again during that Valid cycle, so the next accept is at edge k+RD_LAT+1 at the earliest.
- Read after write: a read of an address written at edge k, accepted at edge k+1 or later, returns the new data.
  - No write can be accepted while a read is in flight, so there is no read/write hazard.
- Reset mid-operation: Reset_n low at any time immediately forces the reset values.
  - Any in-flight read is dropped and never pulses Valid.
  - Storage is re-cleared by CLEAR after reset release.
- Arithmetic: no data arithmetic; widths match exactly and the address covers the full depth, so no address is out of range.

Optional Feature:
- Macro: MEM_RESP_PARITY_EN.
- With the macro defined:
  - Storage is DATA_W+1 bits; bit DATA_W holds the XOR of the data, written on every write and on the clear sweep.
  - On a read response, ParityErr = XOR of the stored DATA_W+1 bits, registered with Valid and high for the same single cycle.
- Without the macro: storage is DATA_W bits and ParityErr is tied to 0.

Decomposition:
- Package mem_pkg holds:
  - ADDR_W and DATA_W defaults;
  - RW_WRITE = 0 and RW_READ = 1;
  - state encodings CLEAR, IDLE and RWAIT as localparams.
- One sub-module, mem_array:
  - 2**ADDR_W x (DATA_W or DATA_W+1) storage with a synchronous write port and an asynchronous read port;
  - no reset on the storage itself.
- mem_responder holds the FSM, the counters and the output registers.

Test Plan:
1. Release reset and track Ready. Expected: Ready stays 0 for exactly 64 edges, then 1. A read of address 63 then gives Valid 2 edges after accept with DataOut = 0.
2. Write addresses 1..10 with data 1..A on consecutive cycles, then read addresses 1..10. Expected: each Valid carries the matching DataOut = address, 2 edges after its accept, and Ready is low during each wait.
3. Issue a read of address 5, then drive a write of address 5 with data F while Ready = 0. Expected: the write is ignored; a later read of address 5 returns 5.
4. Write address 63 with data F and address 0 with data 0, then read both. Expected: F, then 0; DataOut holds F between the two responses.
5. Assert Reset_n low one cycle into RWAIT. Expected: Valid never pulses, DataOut = 0, the CLEAR sweep reruns, and a read of address 3 (previously written) returns 0.
6. With MEM_RESP_PARITY_EN defined, write address 7 with data 6, deposit a flip of stored bit 0, then read address 7. Expected: DataOut = 7 and ParityErr = 1 together with Valid. Without the macro, ParityErr stays 0 throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults, ReadWrite encodings and FSM states for the clocked 64x4 memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 4;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Enable/ReadWrite request bus with Ready/Valid response for mem_responder.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              Enable;
  logic              ReadWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIn;
  logic              Ready;
  logic [DATA_W-1:0] DataOut;
  logic              Valid;
  logic              ParityErr;

  modport master (
    output Enable, ReadWrite, Address, DataIn,
    input  Ready, DataOut, Valid, ParityErr
  );

  modport slave (
    input  Enable, ReadWrite, Address, DataIn,
    output Ready, DataOut, Valid, ParityErr
  );

endinterface

// File: rtl/mem_array.sv
// Unreset word storage: synchronous write port, asynchronous read port.
module mem_array #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Clocked memory responder: post-reset clear sweep, write-in-place, fixed-latency reads.
// Define MEM_RESP_PARITY_EN to store a parity bit per word and flag faults on read.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 2
) (
  input  logic           Clock,
  input  logic           Reset_n,
  mem_responder_if.slave bus
);

`ifdef MEM_RESP_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif
  localparam int unsigned DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [1:0] LAT_INIT  = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   clr_cnt;
  logic [1:0]        lat_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;

  assign accept    = bus.Enable && (state == IDLE);
  assign bus.Ready = (state == IDLE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST) state_nx = IDLE;
      IDLE:    if (accept && bus.ReadWrite == RW_READ) state_nx = RWAIT;
      RWAIT:   if (lat_cnt == 2'd0) state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and accepted writes.
  always_comb begin
    we    = 1'b0;
    waddr = bus.Address;
`ifdef MEM_RESP_PARITY_EN
    wdata = {^bus.DataIn, bus.DataIn};
`else
    wdata = bus.DataIn;
`endif
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt[ADDR_W-1:0];
      wdata = '0;
    end else if (accept && bus.ReadWrite == RW_WRITE) begin
      we = 1'b1;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk   (Clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      clr_cnt <= '0;
      lat_cnt <= '0;
      rd_addr <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        CLEAR: clr_cnt <= clr_cnt + 1'b1;
        IDLE: begin
          if (accept && bus.ReadWrite == RW_READ) begin
            rd_addr <= bus.Address;
            lat_cnt <= LAT_INIT;
          end
        end
        RWAIT: begin
          if (lat_cnt == 2'd0) begin
            dout_q  <= rdata[DATA_W-1:0];
            valid_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic perr_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= (state == RWAIT) && (lat_cnt == 2'd0) && (^rdata);
    end
  end

  assign bus.ParityErr = perr_q;
`else
  assign bus.ParityErr = 1'b0;
`endif

  assign bus.DataOut = dout_q;
  assign bus.Valid   = valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized checks of mem_responder against an array-based reference model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 64;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  mem_responder_if #(.ADDR_W(6), .DATA_W(4)) bus ();

  mem_responder #(
    .ADDR_W (6),
    .DATA_W (4),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  logic [3:0] ref_mem  [DEPTH];
  bit         ref_perr [DEPTH];
  logic [3:0] ref_out;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_perr[i] = 1'b0;
    end
    ref_out = '0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(bus.Ready), 32'd1);
  endtask

  task automatic do_write(input int a, input int d);
    wait_ready();
    bus.Enable    = 1'b1;
    bus.ReadWrite = RW_WRITE;
    bus.Address   = 6'(a);
    bus.DataIn    = 4'(d);
    tick();
    bus.Enable = 1'b0;
    chk("wr_ready", 32'(bus.Ready), 32'd1);
    chk("wr_novalid", 32'(bus.Valid), 32'd0);
    ref_mem[a]  = 4'(d);
    ref_perr[a] = 1'b0;
  endtask

  task automatic do_read(input int a);
    wait_ready();
    bus.Enable    = 1'b1;
    bus.ReadWrite = RW_READ;
    bus.Address   = 6'(a);
    tick();
    bus.Enable = 1'b0;
    chk("rd_busy", 32'(bus.Ready), 32'd0);
    chk("rd_early_valid", 32'(bus.Valid), 32'd0);
    for (int i = 1; i < RD_LAT; i++) begin
      tick();
      chk("rd_wait_ready", 32'(bus.Ready), 32'd0);
      chk("rd_wait_valid", 32'(bus.Valid), 32'd0);
    end
    tick();
    ref_out = ref_mem[a];
    chk("rd_valid", 32'(bus.Valid), 32'd1);
    chk("rd_ready_back", 32'(bus.Ready), 32'd1);
    chk("rd_data", 32'(bus.DataOut), 32'(ref_out));
    chk("rd_perr", 32'(bus.ParityErr), 32'(ref_perr[a]));
    tick();
    chk("rd_pulse_end", 32'(bus.Valid), 32'd0);
    chk("rd_hold", 32'(bus.DataOut), 32'(ref_out));
  endtask

  task automatic count_clear(input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (bus.Ready !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus.Valid === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(n), 32'd64);
    chk("clear_no_valid", 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Enable    = 1'b0;
    bus.ReadWrite = RW_WRITE;
    bus.Address   = '0;
    bus.DataIn    = '0;
    model_clear();

    // 1: reset values, clear sweep length, read of top address
    tick();
    tick();
    chk("rst_ready", 32'(bus.Ready), 32'd0);
    chk("rst_valid", 32'(bus.Valid), 32'd0);
    chk("rst_dout", 32'(bus.DataOut), 32'd0);
    chk("rst_perr", 32'(bus.ParityErr), 32'd0);
    Reset_n = 1'b1;
    count_clear("clear_edges");
    do_read(63);

    // 2: back-to-back writes then read-backs
    for (int a = 1; a <= 10; a++) do_write(a, a);
    for (int a = 1; a <= 10; a++) do_read(a);

    // 3: write presented while busy is ignored
    wait_ready();
    bus.Enable    = 1'b1;
    bus.ReadWrite = RW_READ;
    bus.Address   = 6'd5;
    tick();
    bus.ReadWrite = RW_WRITE;
    bus.DataIn    = 4'hF;
    tick();
    chk("busy_ready", 32'(bus.Ready), 32'd0);
    tick();
    bus.Enable = 1'b0;
    chk("busy_valid", 32'(bus.Valid), 32'd1);
    chk("busy_data", 32'(bus.DataOut), 32'd5);
    tick();
    chk("busy_pulse_end", 32'(bus.Valid), 32'd0);
    do_read(5);

    // 4: address boundaries and DataOut hold
    do_write(63, 15);
    do_write(0, 0);
    do_read(63);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_F", 32'(bus.DataOut), 32'hF);
    end
    do_read(0);

    // 5: reset during RWAIT drops the read and re-clears storage
    do_read(1);
    wait_ready();
    bus.Enable    = 1'b1;
    bus.ReadWrite = RW_READ;
    bus.Address   = 6'd3;
    tick();
    bus.Enable = 1'b0;
    tick();
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.Valid), 32'd0);
    chk("mid_rst_dout", 32'(bus.DataOut), 32'd0);
    chk("mid_rst_ready", 32'(bus.Ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_valid", 32'(bus.Valid), 32'd0);
    end
    Reset_n = 1'b1;
    model_clear();
    count_clear("reclear_edges");
    do_read(3);

    // 6: parity fault injection
    do_write(7, 6);
`ifdef MEM_RESP_PARITY_EN
    dut.u_array.mem[7][0] = ~dut.u_array.mem[7][0];
    ref_mem[7]  = 4'd7;
    ref_perr[7] = 1'b1;
`endif
    do_read(7);

    // randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      int a;
      a = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, int'($urandom_range(0, 15)));
      else                           do_read(a);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
